// File: rtl/hwdata_slicer.sv
// AHB-to-APB write-data slicer: latches one AHB write word and hands it out as APB_DW slices.
// Define HWDATA_SLICER_MSB_FIRST_EN to emit slices most-significant first (big-endian peripheral).
module hwdata_slicer #(
   parameter int  AHB_DW = 32,
   parameter int  APB_DW = 8,
   localparam int N      = AHB_DW / APB_DW,
   localparam int IW     = (N > 1) ? $clog2(N) : 1,
   localparam int AW     = (AHB_DW > 8) ? $clog2(AHB_DW / 8) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [AHB_DW-1:0] i_hwdata,
   input  logic [2:0]        i_hsize,
   input  logic [AW-1:0]     i_addr_lo,
   input  logic              i_next,
   output logic [APB_DW-1:0] o_pwdata,
   output logic              o_valid,
   output logic              o_last,
   output logic              o_busy
);

   localparam int LOGN = $clog2(N);
   localparam int LOGB = $clog2(APB_DW / 8);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [AHB_DW-1:0]   r_word;
   logic [AHB_DW-1:0]   w_wordNext;
   logic [IW-1:0]       r_idx;
   logic [IW-1:0]       w_idxNext;
   logic [IW-1:0]       r_cnt;
   logic [IW-1:0]       w_cntNext;

   int                  w_logBeats;
   logic [IW-1:0]       w_beatsM1;
   logic [IW-1:0]       w_slice;
   logic [IW-1:0]       w_start;
   logic [IW-1:0]       w_first;

   // Beat count is a power of two, so the aligned start slice is the addressed slice with the low bits cleared.
   always_comb begin
      w_logBeats = int'(i_hsize) + 3 - $clog2(APB_DW);
      if (w_logBeats < 0)
         w_logBeats = 0;
      if (w_logBeats > LOGN)
         w_logBeats = LOGN;
      w_beatsM1 = IW'((1 << w_logBeats) - 1);
      w_slice   = IW'(i_addr_lo >> LOGB);
      w_start   = w_slice & ~w_beatsM1;
`ifdef HWDATA_SLICER_MSB_FIRST_EN
      w_first   = w_start | w_beatsM1;
`else
      w_first   = w_start;
`endif
   end

   always_comb begin
      w_stateNext = r_state;
      w_wordNext  = r_word;
      w_idxNext   = r_idx;
      w_cntNext   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_load) begin
               w_wordNext  = i_hwdata;
               w_idxNext   = w_first;
               w_cntNext   = w_beatsM1;
               w_stateNext = SEND;
            end
         end
         SEND: begin
            if (i_next) begin
               if (r_cnt != '0) begin
`ifdef HWDATA_SLICER_MSB_FIRST_EN
                  w_idxNext = r_idx - 1'b1;
`else
                  w_idxNext = r_idx + 1'b1;
`endif
                  w_cntNext = r_cnt - 1'b1;
               end else if (i_load) begin
                  // Back-to-back transfer: the reload takes the place of the final handshake.
                  w_wordNext  = i_hwdata;
                  w_idxNext   = w_first;
                  w_cntNext   = w_beatsM1;
                  w_stateNext = SEND;
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_word  <= w_wordNext;
         r_idx   <= w_idxNext;
         r_cnt   <= w_cntNext;
      end
   end

   // Outputs decode registers only; in IDLE the held slice stays visible but is not valid.
   assign o_pwdata = r_word[int'(r_idx) * APB_DW +: APB_DW];
   assign o_valid  = (r_state == SEND);
   assign o_last   = (r_state == SEND) && (r_cnt == '0);
   assign o_busy   = o_valid;

endmodule

// File: tb/tb_hwdata_slicer.sv
// Self-checking bench for hwdata_slicer: directed test-plan steps followed by random traffic
// compared against a queue-of-pending-slices reference model.
module tb_hwdata_slicer;

   localparam int AHB_DW = 32;
   localparam int APB_DW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_load;
   logic [31:0] i_hwdata;
   logic [2:0]  i_hsize;
   logic [1:0]  i_addr_lo;
   logic        i_next;
   logic [7:0]  o_pwdata;
   logic        o_valid;
   logic        o_last;
   logic        o_busy;

   int nVectors = 0;
   int nMiss    = 0;

   // Reference model: the slices still to be sent, plus the slice shown while idle.
   logic [7:0] q[$];
   logic [7:0] heldIdle;

   logic [7:0] e4[4];
   logic [7:0] f4[4];
   logic [7:0] h2a[2];
   logic [7:0] h2b[2];

   hwdata_slicer #(
      .AHB_DW(AHB_DW),
      .APB_DW(APB_DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_load   (i_load),
      .i_hwdata (i_hwdata),
      .i_hsize  (i_hsize),
      .i_addr_lo(i_addr_lo),
      .i_next   (i_next),
      .o_pwdata (o_pwdata),
      .o_valid  (o_valid),
      .o_last   (o_last),
      .o_busy   (o_busy)
   );

   always #5 clk = ~clk;

   // A transfer covers 2^hsize bytes (at most the whole word), starting at the naturally aligned byte.
   function automatic void modelLoad(input logic [31:0] w, input logic [2:0] hs, input logic [1:0] a);
      int beats;
      int start;
      int idx;
      beats = 1 << int'(hs);
      if (beats > 4)
         beats = 4;
      start = (int'(a) / beats) * beats;
      for (int k = 0; k < beats; k++) begin
`ifdef HWDATA_SLICER_MSB_FIRST_EN
         idx = start + beats - 1 - k;
`else
         idx = start + k;
`endif
         q.push_back(8'((w >> (idx * 8)) & 32'hFF));
      end
   endfunction

   task automatic resetModel();
      q.delete();
      heldIdle = 8'h00;
   endtask

   task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [2:0] hs,
                                input logic [1:0] a, input logic nx);
      i_load    = ld;
      i_hwdata  = d;
      i_hsize   = hs;
      i_addr_lo = a;
      i_next    = nx;
      if (q.size() == 0) begin
         if (ld)
            modelLoad(d, hs, a);
      end else if (nx) begin
         if (q.size() == 1) begin
            heldIdle = q[0];
            q.delete(0);
            if (ld)
               modelLoad(d, hs, a);
         end else begin
            q.delete(0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic       expValid;
      logic       expLast;
      logic [7:0] expData;
      expValid = (q.size() > 0);
      expLast  = (q.size() == 1);
      expData  = expValid ? q[0] : heldIdle;
      nVectors++;
      assert (o_valid === expValid) else begin
         nMiss++;
         $error("[TB] FAIL %s model o_valid: got %b expected %b", tag, o_valid, expValid);
      end
      nVectors++;
      assert (o_last === expLast) else begin
         nMiss++;
         $error("[TB] FAIL %s model o_last: got %b expected %b", tag, o_last, expLast);
      end
      nVectors++;
      assert (o_pwdata === expData) else begin
         nMiss++;
         $error("[TB] FAIL %s model o_pwdata: got %h expected %h", tag, o_pwdata, expData);
      end
      nVectors++;
      assert (o_busy === expValid) else begin
         nMiss++;
         $error("[TB] FAIL %s model o_busy: got %b expected %b", tag, o_busy, expValid);
      end
   endtask

   task automatic checkExpect(input string tag, input logic v, input logic l, input logic [7:0] d);
      nVectors++;
      assert (o_valid === v) else begin
         nMiss++;
         $error("[TB] FAIL %s o_valid: got %b expected %b", tag, o_valid, v);
      end
      nVectors++;
      assert (o_last === l) else begin
         nMiss++;
         $error("[TB] FAIL %s o_last: got %b expected %b", tag, o_last, l);
      end
      nVectors++;
      assert (o_pwdata === d) else begin
         nMiss++;
         $error("[TB] FAIL %s o_pwdata: got %h expected %h", tag, o_pwdata, d);
      end
   endtask

   initial begin
`ifdef HWDATA_SLICER_MSB_FIRST_EN
      e4  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      f4  = '{8'h11, 8'h22, 8'h33, 8'h44};
      h2a = '{8'hAA, 8'hBB};
      h2b = '{8'hCC, 8'hDD};
`else
      e4  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      f4  = '{8'h44, 8'h33, 8'h22, 8'h11};
      h2a = '{8'hBB, 8'hAA};
      h2b = '{8'hDD, 8'hCC};
`endif
      rst       = 1'b0;
      i_load    = 1'b0;
      i_hwdata  = '0;
      i_hsize   = '0;
      i_addr_lo = '0;
      i_next    = 1'b0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      checkExpect("reset", 1'b0, 1'b0, 8'h00);
      checkOutput("reset");
      rst = 1'b1;

      $display("[TB] full word, i_next held high");
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd2, 2'd0, 1'b1);
      checkExpect("word0", 1'b1, 1'b0, e4[0]);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
         checkExpect("wordN", 1'b1, (k == 3), e4[k]);
      end
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("wordEnd", 1'b0, 1'b0, e4[3]);
      checkOutput("wordEnd");

      $display("[TB] byte and halfword transfers");
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd0, 2'd2, 1'b0);
      checkExpect("byte", 1'b1, 1'b1, 8'hBB);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0);
      checkExpect("byteHold", 1'b1, 1'b1, 8'hBB);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("byteEnd", 1'b0, 1'b0, 8'hBB);
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd1, 2'd2, 1'b1);
      checkExpect("half2a", 1'b1, 1'b0, h2a[0]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("half2b", 1'b1, 1'b1, h2a[1]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("half2End", 1'b0, 1'b0, h2a[1]);
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd1, 2'd0, 1'b1);
      checkExpect("half0a", 1'b1, 1'b0, h2b[0]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("half0b", 1'b1, 1'b1, h2b[1]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkOutput("half0End");

      $display("[TB] stall, ignored load, back-to-back reload");
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd2, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0);
         checkExpect("stall", 1'b1, 1'b0, e4[0]);
      end
      applyStimulus(1'b1, 32'h11223344, 3'd2, 2'd0, 1'b1);
      checkExpect("ignLoadNext", 1'b1, 1'b0, e4[1]);
      applyStimulus(1'b1, 32'h11223344, 3'd2, 2'd0, 1'b0);
      checkExpect("ignLoadHold", 1'b1, 1'b0, e4[1]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("resume2", 1'b1, 1'b0, e4[2]);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("resume3", 1'b1, 1'b1, e4[3]);
      applyStimulus(1'b1, 32'h11223344, 3'd2, 2'd0, 1'b1);
      checkExpect("b2b0", 1'b1, 1'b0, f4[0]);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
         checkExpect("b2bN", 1'b1, (k == 3), f4[k]);
      end
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkOutput("b2bEnd");

      $display("[TB] asynchronous reset mid-transfer");
      applyStimulus(1'b1, 32'hAABBCCDD, 3'd2, 2'd0, 1'b1);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("preRst", 1'b1, 1'b0, e4[1]);
      i_next = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      resetModel();
      checkExpect("asyncRst", 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      checkExpect("inRst", 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkExpect("postRst", 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1);
      checkOutput("postRstIdle");

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         logic       ld;
         logic       nx;
         logic [2:0] hs;
         logic [1:0] a;
         ld = ($urandom_range(0, 99) < 30);
         nx = ($urandom_range(0, 99) < 65);
         hs = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         a  = 2'($urandom_range(0, 3));
         applyStimulus(ld, $urandom, hs, a, nx);
         checkOutput("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule

// File: doc/hwdata_slicer.md
# hwdata_slicer

Write-data slicer for the AHB-to-APB bridge: the write-direction counterpart of the read-data assembly path. It captures one AHB write word (`AHB_DW` wide) and presents it to the APB master FSM as a sequence of `APB_DW`-wide slices on `o_pwdata`, one slice per APB write. It advances on a per-slice handshake from the APB side and flags the final slice. The slices cover only the byte lanes selected by `HSIZE` and the low address bits.

## Interface
Parameters:
- `AHB_DW`, 32, AHB write-data width; `AHB_DW/APB_DW` is a power of two (N slices).
- `APB_DW`, 8, APB data width; ≥ 8, a multiple of 8, ≤ `AHB_DW`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_load`  in  1  capture request: latch word, size and address.
- `i_hwdata`  in  `AHB_DW`  AHB write word.
- `i_hsize`  in  3  AHB `HSIZE`; transfer bytes = 2^`i_hsize`.
- `i_addr_lo`  in  log2(`AHB_DW`/8)  low bits of `HADDR`.
- `i_next`  in  1  APB write of the current slice completed (`PREADY` accepted).
- `o_pwdata`  out  `APB_DW`  current slice.
- `o_valid`  out  1  a slice is pending.
- `o_last`  out  1  the current slice is the final one of the transfer.
- `o_busy`  out  1  equals `o_valid`; load is blocked except on the final handshake.

## Operation
- Registers:
  - `word_q` (`AHB_DW`)
  - `idx_q` (slice index, log2 N bits)
  - `cnt_q` (remaining beats − 1)
  - `state_q`
- Every register resets to 0. After reset, all outputs are 0.
- Beat count: `beats = max(1, (2^i_hsize * 8) / APB_DW)`, clamped to N.
- Start slice: `start = (i_addr_lo * 8 / APB_DW)`, rounded down to a multiple of `beats`. This keeps the transfer naturally aligned. Misaligned `HADDR` relative to `HSIZE` is not checked.
- FSM `IDLE`:
  - `o_valid = 0`.
  - On `i_load`: `word_q <= i_hwdata`, `idx_q <= start`, `cnt_q <= beats-1`, go to `SEND`.
- FSM `SEND`:
  - `o_valid = 1`.
  - `o_last = (cnt_q == 0)`.
  - `o_pwdata = word_q[idx_q*APB_DW +: APB_DW]`.
- In `SEND`, on `i_next` with `cnt_q != 0`: `idx_q <= idx_q+1`, `cnt_q <= cnt_q-1`. The index wraps modulo N, but never does so within a legal aligned transfer.
- In `SEND`, on `i_next` with `cnt_q == 0`:
  - With `i_load` also high: reload immediately (back-to-back transfer) and stay in `SEND`.
  - Otherwise: go to `IDLE`.
- `i_load` in `SEND` when not (`i_next` and `o_last`): ignored. The word is not overwritten, and the bridge must not issue it.
- `i_next` in `IDLE`: ignored.
- `o_pwdata` in `IDLE`: shows the slice at `idx_q` of the held word. It is don't-care for the APB side, but deterministic: 0 after reset.
- `o_pwdata`, `o_last` and `o_valid` are combinational decodes of registers only. There is no input-to-output combinational path.

## Timing
- Load accepted at edge k → `o_valid = 1` and first slice on `o_pwdata` from cycle k+1.
- Each `i_next` at edge m → next slice visible from cycle m+1. With `i_next` held high, throughput is 1 slice/cycle.
- `i_next` low → slice, `o_valid` and `o_last` hold indefinitely.
- Transfer of `beats` slices: final `i_next` at edge e → `o_valid = 0` at e+1, unless a same-edge reload occurs, in which case the new first slice appears at e+1.
- `rst` asserted mid-transfer → immediate return to `IDLE`, all registers 0, `o_valid = 0`. The pending slices are discarded.

## Configuration
- `HWDATA_SLICER_MSB_FIRST_EN`:
  - Defined: slices are emitted most-significant first. Set `idx_q <= start+beats-1` and decrement on each `i_next`. This supports a big-endian APB peripheral.
  - Undefined (default): least-significant first, as described in Operation.
- The beat count, `o_last` and the timing are identical in both builds.

## Test plan
All scenarios use `AHB_DW = 32`, `APB_DW = 8`.
- Reset, then load `0xAABBCCDD`, `hsize = 2`, `addr_lo = 0`, with `i_next` held high → `o_pwdata` is `DD`, `CC`, `BB`, `AA` on consecutive cycles; `o_last` only on `AA`; `o_valid` falls the next cycle.
- Load `0xAABBCCDD`, `hsize = 0`, `addr_lo = 2` → single slice `BB` with `o_last = 1`. Halfword (`hsize = 1`), `addr_lo = 2` → `BB`, then `AA`.
- Stall: word load, `i_next` low for 5 cycles after the first slice → `DD` held with `o_valid = 1` and `o_last = 0`. Then resume → `CC`, `BB`, `AA`.
- Load in `SEND` mid-transfer (`0x11223344`) → ignored, remaining slices come from the old word. Load asserted on the final `i_next` → `44`, `33`, `22`, `11` follows with no idle cycle.
- `rst` low after 2 of 4 slices → `o_valid`, `o_last` and `o_pwdata` are 0 immediately. After release, the FSM is idle until the next load.
- With `HWDATA_SLICER_MSB_FIRST_EN`: word `0xAABBCCDD` → `AA`, `BB`, `CC`, `DD`; halfword at `addr_lo = 0` → `CC`, `DD`.
